rsync_retimer: RTL
==================

# rsync_retimer

Parametrised retiming stage for the current-steering DAC data path: captures complementary thermometer and binary data words and realigns the two groups with programmable per-group cycle delays. Drives complementary outputs to the cell drivers under a power-down/flush sequencer. It is the synthesizable successor of the fixed 17-thermometer / 7-binary retiming latch. Adds integrity monitoring (complement check, thermometer bubble counting) and a digital test-bus observation mux.

## Interface
- N_THERM, 17, thermometer cell count
- N_BIN, 7, binary bit count
- MAX_DLY, 3, maximum extra alignment delay per group in cycles (≥1); DW = $clog2(MAX_DLY+1)
- clkin  in  1  single DAC-side clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- pdb  in  1  power-down bar; 0 forces OFF
- dataintherm / datainthermb  in  N_THERM  thermometer data and complement
- datainbin / datainbinb  in  N_BIN  binary data and complement
- dly_therm / dly_bin  in  DW  extra delay for each group; values > MAX_DLY clamp to MAX_DLY
- atb_ena  in  2  test-bus select
- dataouttherm / dataoutthermb  out  N_THERM  retimed thermometer and complement
- dataoutbin / dataoutbinb  out  N_BIN  retimed binary and complement
- ready  out  1  high in ACTIVE only
- comp_err  out  1  sticky complement-violation flag
- bubble_cnt  out  8  saturating count of invalid thermometer codes
- atb0 / atb1  out  1  registered test-bus outputs

## Operation
- Capture register samples all four data inputs every cycle, in every state.
- Complement check, per bit at capture: if data bit == its complement bit, the captured bit keeps its previous captured value (hold-on-error) and comp_err sets. comp_err clears only on rst.
- Thermometer check on captured dataintherm: valid iff the value equals 2^k−1 for some k in 0..N_THERM (LSB-filled). An invalid code passes through unchanged; bubble_cnt increments once per invalid cycle and saturates at 255. Counting occurs only in ACTIVE.
- Delay lines: each group passes through a MAX_DLY-deep shift register. Tap index = clamped dly value; tap 0 bypasses the shift register.
- Output register: dataout* = delayed data; dataout*b = bitwise inverse of dataout*, generated from the same register (never from the input complements).
- FSM states:
  - OFF → FLUSH when pdb=1.
  - FLUSH counts MAX_DLY+2 cycles, then → ACTIVE.
  - In any state, pdb=0 → OFF on the next edge.
  - In ACTIVE, any change of dly_therm or dly_bin (vs. the previous cycle's value) → FLUSH with the counter restarted.
- Quiescent outputs in OFF and FLUSH: dataout* = 0, dataout*b = all ones, ready = 0.
- atb mux (registered):
  - 00 → atb0=0, atb1=0
  - 01 → atb0=comp_err, atb1=ready
  - 10 → atb0=dataouttherm[0], atb1=dataoutbin[0]
  - 11 → atb0=^dataouttherm, atb1=^dataoutbin

## Timing
- Reset values: dataout*=0, dataout*b=all ones, ready=0, comp_err=0, bubble_cnt=0, atb0=atb1=0, FSM=OFF, capture and delay registers=0.
- Latency, in ACTIVE: input sampled at edge n appears on dataout at edge n+2+dly of its group.
- Group skew therefore equals dly_therm − dly_bin cycles.
- ready rises MAX_DLY+2 cycles after the first edge sampling pdb=1. It falls on the edge that samples pdb=0 or a dly change.
- The first non-quiescent output coincides with ready rising. Delay-line contents are fully refreshed by then.
- rst has priority over pdb and all other inputs. rst asserted mid-ACTIVE restores reset values on that edge.
- pdb=0 and a dly change in the same cycle: OFF wins.
- bubble_cnt at 255 holds; comp_err and bubble_cnt persist across pdb cycles.
- atb outputs lag their sources by one cycle.

## Test plan
- Reset/OFF: rst=1 for 2 cycles, pdb=0 → all dataout*=0, dataout*b=all ones, ready=0, atb=0; pdb=1 at cycle 0 with MAX_DLY=3 → ready=1 at cycle 5.
- Latency: dly_therm=0, dly_bin=2, dataintherm=17'h000FF and datainbin=7'h55 for one cycle → therm appears 2 cycles later, bin 4 cycles later; complements exact inverses.
- Complement fault: datainbin[3]=datainbinb[3]=1 for one cycle with previous bit 0 → dataoutbin[3] stays 0, comp_err=1 until rst; atb_ena=01 → atb0=1 one cycle later.
- Bubbles: 300 consecutive cycles of dataintherm=17'h00005 in ACTIVE → bubble_cnt saturates at 255; code 17'h1FFFF adds nothing.
- Dly change mid-stream: dly_therm 1→3 in ACTIVE → ready=0 next edge, quiescent outputs for 5 cycles, then ready=1 with 5-cycle therm latency.
- pdb drop plus simultaneous dly change in ACTIVE → OFF, quiescent outputs next edge; atb_ena=11 with dataouttherm=17'h00007 → atb0=1.

Source files
------------

// File: rtl/rsync_retimer_if.sv
// Data bus of the DAC retimer: complementary thermometer/binary words in, retimed
// complementary words out.
interface rsync_retimer_if #(
  parameter int unsigned N_THERM = 17,
  parameter int unsigned N_BIN   = 7
);
  logic [N_THERM-1:0] dataintherm;
  logic [N_THERM-1:0] datainthermb;
  logic [N_BIN-1:0]   datainbin;
  logic [N_BIN-1:0]   datainbinb;
  logic [N_THERM-1:0] dataouttherm;
  logic [N_THERM-1:0] dataoutthermb;
  logic [N_BIN-1:0]   dataoutbin;
  logic [N_BIN-1:0]   dataoutbinb;

  modport master (
    output dataintherm, datainthermb, datainbin, datainbinb,
    input  dataouttherm, dataoutthermb, dataoutbin, dataoutbinb
  );

  modport slave (
    input  dataintherm, datainthermb, datainbin, datainbinb,
    output dataouttherm, dataoutthermb, dataoutbin, dataoutbinb
  );
endinterface

// File: rtl/rsync_retimer.sv
// Retiming stage for the current-steering DAC: complement-checked capture, per-group
// programmable alignment delay, power-down/flush sequencing, integrity monitors and test bus.
module rsync_retimer #(
  parameter int unsigned N_THERM = 17,
  parameter int unsigned N_BIN   = 7,
  parameter int unsigned MAX_DLY = 3,
  localparam int unsigned DW     = $clog2(MAX_DLY + 1)
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          pdb,
  input  logic [DW-1:0] dly_therm,
  input  logic [DW-1:0] dly_bin,
  input  logic [1:0]    atb_ena,
  rsync_retimer_if.slave bus,
  output logic          ready,
  output logic          comp_err,
  output logic [7:0]    bubble_cnt,
  output logic          atb0,
  output logic          atb1
);

  localparam int unsigned CW = $clog2(MAX_DLY + 2);

  typedef enum logic [1:0] {S_OFF, S_FLUSH, S_ACTIVE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [DW-1:0]      dly_therm_q, dly_bin_q;
  logic               dly_chg;

  logic [N_THERM-1:0] cap_therm, stg_therm, out_therm;
  logic [N_BIN-1:0]   cap_bin, stg_bin, out_bin;
  logic [N_THERM-1:0] dl_therm [MAX_DLY];
  logic [N_BIN-1:0]   dl_bin   [MAX_DLY];
  logic [N_THERM-1:0] taps_therm [MAX_DLY+1];
  logic [N_BIN-1:0]   taps_bin   [MAX_DLY+1];

  logic [N_THERM-1:0] therm_bad, therm_inc;
  logic [N_BIN-1:0]   bin_bad;
  logic               therm_valid;
  logic [DW-1:0]      sel_therm, sel_bin;
  logic               active_next;

  function automatic logic [DW-1:0] clamp_dly(input logic [DW-1:0] d);
    if ({1'b0, d} > (DW+1)'(MAX_DLY)) return DW'(MAX_DLY);
    return d;
  endfunction

  // A bit equal to its complement is a violation; such bits hold their last capture.
  assign therm_bad   = ~(bus.dataintherm ^ bus.datainthermb);
  assign bin_bad     = ~(bus.datainbin ^ bus.datainbinb);
  assign therm_inc   = cap_therm + N_THERM'(1);
  assign therm_valid = ((cap_therm & therm_inc) == '0);
  assign dly_chg     = (dly_therm != dly_therm_q) || (dly_bin != dly_bin_q);
  assign sel_therm   = clamp_dly(dly_therm);
  assign sel_bin     = clamp_dly(dly_bin);
  assign active_next = (state_next == S_ACTIVE);

  always_comb begin
    taps_therm[0] = stg_therm;
    taps_bin[0]   = stg_bin;
    for (int i = 1; i <= int'(MAX_DLY); i++) begin
      taps_therm[i] = dl_therm[i-1];
      taps_bin[i]   = dl_bin[i-1];
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // pdb low overrides every other transition, including a dly change.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_OFF: begin
        if (pdb) begin
          state_next = S_FLUSH;
          cnt_next   = '0;
        end
      end
      S_FLUSH: begin
        if (cnt == CW'(MAX_DLY + 1)) state_next = S_ACTIVE;
        else                         cnt_next   = cnt + CW'(1);
      end
      S_ACTIVE: begin
        if (dly_chg) begin
          state_next = S_FLUSH;
          cnt_next   = '0;
        end
      end
      default: state_next = S_OFF;
    endcase
    if (!pdb) begin
      state_next = S_OFF;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      cap_therm   <= '0;
      cap_bin     <= '0;
      stg_therm   <= '0;
      stg_bin     <= '0;
      dly_therm_q <= '0;
      dly_bin_q   <= '0;
      for (int i = 0; i < int'(MAX_DLY); i++) begin
        dl_therm[i] <= '0;
        dl_bin[i]   <= '0;
      end
    end else begin
      cap_therm   <= (bus.dataintherm & ~therm_bad) | (cap_therm & therm_bad);
      cap_bin     <= (bus.datainbin & ~bin_bad) | (cap_bin & bin_bad);
      stg_therm   <= cap_therm;
      stg_bin     <= cap_bin;
      dly_therm_q <= dly_therm;
      dly_bin_q   <= dly_bin;
      dl_therm[0] <= stg_therm;
      dl_bin[0]   <= stg_bin;
      for (int i = 1; i < int'(MAX_DLY); i++) begin
        dl_therm[i] <= dl_therm[i-1];
        dl_bin[i]   <= dl_bin[i-1];
      end
    end
  end

  // Output, status and monitor registers; outputs are quiescent outside ACTIVE.
  always_ff @(posedge clkin) begin
    if (rst) begin
      out_therm  <= '0;
      out_bin    <= '0;
      ready      <= 1'b0;
      comp_err   <= 1'b0;
      bubble_cnt <= '0;
      atb0       <= 1'b0;
      atb1       <= 1'b0;
    end else begin
      out_therm <= active_next ? taps_therm[sel_therm] : '0;
      out_bin   <= active_next ? taps_bin[sel_bin] : '0;
      ready     <= active_next;
      comp_err  <= comp_err | (|therm_bad) | (|bin_bad);
      if ((state == S_ACTIVE) && !therm_valid && (bubble_cnt != 8'hFF))
        bubble_cnt <= bubble_cnt + 8'd1;
      case (atb_ena)
        2'b00: begin atb0 <= 1'b0;         atb1 <= 1'b0;       end
        2'b01: begin atb0 <= comp_err;     atb1 <= ready;      end
        2'b10: begin atb0 <= out_therm[0]; atb1 <= out_bin[0]; end
        default: begin atb0 <= ^out_therm; atb1 <= ^out_bin;   end
      endcase
    end
  end

  // Complement outputs come from the same register as the true outputs.
  assign bus.dataouttherm  = out_therm;
  assign bus.dataoutthermb = ~out_therm;
  assign bus.dataoutbin    = out_bin;
  assign bus.dataoutbinb   = ~out_bin;

endmodule
